// File: rtl/cpu_ctrl_pkg.sv
// Shared control-word bit positions and opcode values for the 8-bit bus CPU.
// The datapath blocks import this package so their ctrl bit picks stay in sync.
package cpu_ctrl_pkg;

    localparam int MAX_STEP = 4;

    localparam int CW_HLT = 15;
    localparam int CW_MI  = 14;
    localparam int CW_RI  = 13;
    localparam int CW_RO  = 12;
    localparam int CW_IO  = 11;
    localparam int CW_II  = 10;
    localparam int CW_AI  = 9;
    localparam int CW_AO  = 8;
    localparam int CW_EO  = 7;
    localparam int CW_SU  = 6;
    localparam int CW_BI  = 5;
    localparam int CW_OI  = 4;
    localparam int CW_CE  = 3;
    localparam int CW_CO  = 2;
    localparam int CW_JMP = 1;
    localparam int CW_FI  = 0;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Opcodes that have at least one execute step; anything else ends after fetch.
    function automatic logic has_exec(input logic [3:0] op);
        case (op)
            OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI,
            OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: has_exec = 1'b1;
            default:                              has_exec = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_microcode_rom.sv
// Combinational microcode: (opcode, step, flags) -> control word plus a flag
// marking the final active step of the instruction.
module microcode_rom
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int STEP_W   = 3,
    parameter int CW_W     = 16
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [STEP_W-1:0]   step,
    input  logic                cf,
    input  logic                zf,
    output logic [CW_W-1:0]     ctrl,
    output logic                last_step
);

    always_comb begin
        ctrl      = '0;
        last_step = 1'b0;
        case (int'(step))
            0: begin
                ctrl[CW_CO] = 1'b1;
                ctrl[CW_MI] = 1'b1;
            end
            1: begin
                ctrl[CW_RO] = 1'b1;
                ctrl[CW_II] = 1'b1;
                ctrl[CW_CE] = 1'b1;
                last_step   = !has_exec(opcode);
            end
            2: begin
                last_step = 1'b1;
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ctrl[CW_IO] = 1'b1;
                        ctrl[CW_MI] = 1'b1;
                        last_step   = 1'b0;
                    end
                    OP_LDI: begin
                        ctrl[CW_IO] = 1'b1;
                        ctrl[CW_AI] = 1'b1;
                    end
                    OP_JMP: begin
                        ctrl[CW_IO]  = 1'b1;
                        ctrl[CW_JMP] = 1'b1;
                    end
                    // Conditional jumps that are not taken still burn T2 as an idle step.
                    OP_JC: begin
                        ctrl[CW_IO]  = cf;
                        ctrl[CW_JMP] = cf;
                    end
                    OP_JZ: begin
                        ctrl[CW_IO]  = zf;
                        ctrl[CW_JMP] = zf;
                    end
                    OP_OUT: begin
                        ctrl[CW_AO] = 1'b1;
                        ctrl[CW_OI] = 1'b1;
                    end
                    OP_HLT: ctrl[CW_HLT] = 1'b1;
                    default: ;
                endcase
            end
            3: begin
                last_step = 1'b1;
                case (opcode)
                    OP_LDA: begin
                        ctrl[CW_RO] = 1'b1;
                        ctrl[CW_AI] = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl[CW_RO] = 1'b1;
                        ctrl[CW_BI] = 1'b1;
                        last_step   = 1'b0;
                    end
                    OP_STA: begin
                        ctrl[CW_AO] = 1'b1;
                        ctrl[CW_RI] = 1'b1;
                    end
                    default: ;
                endcase
            end
            4: begin
                last_step = 1'b1;
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    ctrl[CW_EO] = 1'b1;
                    ctrl[CW_AI] = 1'b1;
                    ctrl[CW_FI] = 1'b1;
                    ctrl[CW_SU] = (opcode == OP_SUB);
                end
            end
            default: last_step = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// T-step counter and halt latch around the microcode ROM; masks the control
// word during reset and while halted.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int STEP_W   = 3,
    parameter int CW_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                cf,
    input  logic                zf,
    output logic [CW_W-1:0]     ctrl,
    output logic [STEP_W-1:0]   step,
    output logic                halted
);

    logic [STEP_W-1:0] step_q, step_nxt;
    logic              halted_q, halted_nxt;
    logic [CW_W-1:0]   rom_ctrl;
    logic              rom_last;

    microcode_rom #(
        .OPCODE_W (OPCODE_W),
        .STEP_W   (STEP_W),
        .CW_W     (CW_W)
    ) u_rom (
        .opcode    (opcode),
        .step      (step_q),
        .cf        (cf),
        .zf        (zf),
        .ctrl      (rom_ctrl),
        .last_step (rom_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_nxt;
            halted_q <= halted_nxt;
        end
    end

    // HLT freezes the counter at its own step; only reset releases it.
    always_comb begin
        step_nxt   = step_q;
        halted_nxt = halted_q;
        if (!halted_q) begin
            if (rom_ctrl[CW_HLT])
                halted_nxt = 1'b1;
            else if (rom_last || step_q >= STEP_W'(MAX_STEP))
                step_nxt = '0;
            else
                step_nxt = step_q + 1'b1;
        end
    end

    always_comb begin
        ctrl = '0;
        if (!rst) begin
            if (halted_q)
                ctrl[CW_HLT] = 1'b1;
            else
                ctrl = rom_ctrl;
        end
    end

    assign step   = step_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed scenario tasks plus a sweep/random run against an instruction-level
// model that replays each opcode's list of control words.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  opcode = 4'h0;
    logic        cf = 1'b0;
    logic        zf = 1'b0;
    logic [15:0] ctrl;
    logic [2:0]  step;
    logic        halted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    control_sequencer #(.OPCODE_W(4), .STEP_W(3), .CW_W(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .cf     (cf),
        .zf     (zf),
        .ctrl   (ctrl),
        .step   (step),
        .halted (halted)
    );

    task automatic go(input logic r, input logic [3:0] op, input logic c, input logic z);
        @(negedge clk);
        rst = r; opcode = op; cf = c; zf = z;
        #1;
    endtask

    task automatic test_reset;
        go(1, 4'h0, 0, 0);
        go(1, 4'h0, 0, 0);
        checks++; if (ctrl !== 16'h0000) begin errors++; $display("FAIL reset_ctrl got %h want 0000", ctrl); end
        checks++; if (step !== 3'd0) begin errors++; $display("FAIL reset_step got %0d want 0", step); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
        go(0, 4'h0, 0, 0);
        checks++; if (ctrl !== 16'h4004) begin errors++; $display("FAIL fetch_t0 got %h want 4004", ctrl); end
        go(0, 4'h0, 0, 0);
        checks++; if (ctrl !== 16'h1408 || step !== 3'd1) begin errors++; $display("FAIL fetch_t1 got %h/%0d want 1408/1", ctrl, step); end
    endtask

    task automatic test_lda;
        go(1, 4'h1, 0, 0);
        go(0, 4'h1, 0, 0);
        go(0, 4'h1, 0, 0);
        go(0, 4'h1, 0, 0);
        checks++; if (ctrl !== 16'h4800 || step !== 3'd2) begin errors++; $display("FAIL lda_t2 got %h/%0d want 4800/2", ctrl, step); end
        go(0, 4'h1, 0, 0);
        checks++; if (ctrl !== 16'h1200 || step !== 3'd3) begin errors++; $display("FAIL lda_t3 got %h/%0d want 1200/3", ctrl, step); end
        go(0, 4'h1, 0, 0);
        checks++; if (step !== 3'd0) begin errors++; $display("FAIL lda_end got %0d want 0", step); end
    endtask

    task automatic test_sub_nop;
        go(1, 4'h3, 0, 0);
        for (int i = 0; i < 5; i++) go(0, 4'h3, 1, 1);
        checks++; if (ctrl !== 16'h02C1 || step !== 3'd4) begin errors++; $display("FAIL sub_t4 got %h/%0d want 02c1/4", ctrl, step); end
        go(0, 4'h0, 0, 0);
        checks++; if (step !== 3'd0) begin errors++; $display("FAIL sub_end got %0d want 0", step); end
        go(0, 4'h0, 0, 0);
        checks++; if (step !== 3'd1) begin errors++; $display("FAIL nop_t1 got %0d want 1", step); end
        go(0, 4'h0, 0, 0);
        checks++; if (step !== 3'd0) begin errors++; $display("FAIL nop_end got %0d want 0", step); end
    endtask

    task automatic test_jc;
        go(1, 4'h7, 0, 0);
        for (int i = 0; i < 3; i++) go(0, 4'h7, 0, 1);
        checks++; if (ctrl !== 16'h0000 || step !== 3'd2) begin errors++; $display("FAIL jc_nt_t2 got %h/%0d want 0000/2", ctrl, step); end
        go(0, 4'h7, 1, 0);
        checks++; if (step !== 3'd0) begin errors++; $display("FAIL jc_nt_end got %0d want 0", step); end
        go(0, 4'h7, 1, 0);
        go(0, 4'h7, 1, 0);
        checks++; if (ctrl !== 16'h0802) begin errors++; $display("FAIL jc_t_t2 got %h want 0802", ctrl); end
        go(0, 4'h7, 1, 0);
        checks++; if (step !== 3'd0) begin errors++; $display("FAIL jc_t_end got %0d want 0", step); end
    endtask

    task automatic test_hlt;
        go(1, 4'hF, 0, 0);
        for (int i = 0; i < 3; i++) go(0, 4'hF, 0, 0);
        checks++; if (ctrl !== 16'h8000 || halted !== 1'b0) begin errors++; $display("FAIL hlt_t2 got %h/%b want 8000/0", ctrl, halted); end
        for (int i = 0; i < 10; i++) begin
            go(0, 4'(i), i[0], i[1]);
            checks++;
            if (halted !== 1'b1 || step !== 3'd2 || ctrl !== 16'h8000 || ctrl[3] !== 1'b0) begin
                errors++; $display("FAIL hlt_hold cyc %0d got %b/%0d/%h want 1/2/8000", i, halted, step, ctrl);
            end
        end
        go(1, 4'hF, 0, 0);
        checks++; if (ctrl !== 16'h0000) begin errors++; $display("FAIL hlt_rst_ctrl got %h want 0000", ctrl); end
        go(0, 4'hF, 0, 0);
        checks++; if (halted !== 1'b0 || step !== 3'd0 || ctrl !== 16'h4004) begin
            errors++; $display("FAIL hlt_release got %b/%0d/%h want 0/0/4004", halted, step, ctrl);
        end
    endtask

    task automatic test_rst_mid;
        go(1, 4'h2, 0, 0);
        for (int i = 0; i < 4; i++) go(0, 4'h2, 0, 0);
        checks++; if (ctrl !== 16'h1020 || step !== 3'd3) begin errors++; $display("FAIL add_t3 got %h/%0d want 1020/3", ctrl, step); end
        go(1, 4'h2, 0, 0);
        go(0, 4'h2, 0, 0);
        checks++; if (step !== 3'd0 || ctrl !== 16'h4004) begin errors++; $display("FAIL rst_mid got %0d/%h want 0/4004", step, ctrl); end
    endtask

    // Model: each instruction is the list of control words it issues, in order.
    // -1 / -2 stand for the JC / JZ word, resolved from the flag seen that cycle.
    task automatic test_model_sweep;
        int          m_q[$];
        int          m_step = 0;
        bit          m_halt = 1'b0;
        logic [3:0]  cur_op = 4'h0;
        logic        r, c, z;
        logic [15:0] exp_c;
        int          w, drivers;
        for (int k = 0; k < 2100; k++) begin
            if (k < 576) begin
                r = (k % 9 == 0);
                cur_op = 4'((k / 9) / 4);
                c = ((k / 9) % 4) >= 2;
                z = ((k / 9) % 2) == 1;
            end else begin
                r = ($urandom_range(0, 39) == 0);
                if (!m_halt && m_q.size() == 0) cur_op = 4'($urandom_range(0, 15));
                c = 1'($urandom_range(0, 1));
                z = 1'($urandom_range(0, 1));
            end
            go(r, cur_op, c, z);
            if (r) begin
                checks++; if (ctrl !== 16'h0000) begin errors++; $display("FAIL model_rst cyc %0d got %h want 0000", k, ctrl); end
                m_q.delete(); m_step = 0; m_halt = 1'b0;
            end else if (m_halt) begin
                checks++;
                if (ctrl !== 16'h8000 || step !== 3'd2 || halted !== 1'b1) begin
                    errors++; $display("FAIL model_halt cyc %0d got %h/%0d/%b want 8000/2/1", k, ctrl, step, halted);
                end
            end else begin
                if (m_q.size() == 0) begin
                    m_q = '{32'h4004, 32'h1408};
                    case (cur_op)
                        4'h1: m_q = {m_q, 32'h4800, 32'h1200};
                        4'h2: m_q = {m_q, 32'h4800, 32'h1020, 32'h0281};
                        4'h3: m_q = {m_q, 32'h4800, 32'h1020, 32'h02C1};
                        4'h4: m_q = {m_q, 32'h4800, 32'h2100};
                        4'h5: m_q.push_back(32'h0A00);
                        4'h6: m_q.push_back(32'h0802);
                        4'h7: m_q.push_back(-1);
                        4'h8: m_q.push_back(-2);
                        4'hE: m_q.push_back(32'h0110);
                        4'hF: m_q.push_back(32'h8000);
                        default: ;
                    endcase
                end
                w = m_q.pop_front();
                if (w == -1)      exp_c = c ? 16'h0802 : 16'h0000;
                else if (w == -2) exp_c = z ? 16'h0802 : 16'h0000;
                else              exp_c = w[15:0];
                checks++;
                if (ctrl !== exp_c || step !== 3'(m_step) || halted !== 1'b0) begin
                    errors++; $display("FAIL model op %h cyc %0d got %h/%0d/%b want %h/%0d/0", cur_op, k, ctrl, step, halted, exp_c, m_step);
                end
                if (exp_c == 16'h8000) m_halt = 1'b1;
                else if (m_q.size() == 0) m_step = 0;
                else m_step++;
            end
            drivers = $countones({ctrl[2], ctrl[12], ctrl[11], ctrl[8], ctrl[7]});
            checks++; if (drivers > 1) begin errors++; $display("FAIL bus_onehot cyc %0d ctrl %h drivers %0d want <=1", k, ctrl, drivers); end
        end
    endtask

    initial begin
        test_reset;
        test_lda;
        test_sub_nop;
        test_jc;
        test_hlt;
        test_rst_mid;
        test_model_sweep;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
